// File: rtl/sreg_target_if.sv
// Serial configuration link between sreg_ctrl (master) and sreg_target (slave).
interface sreg_target_if;
  logic       shift;
  logic       sclk;
  logic       serial_in;
  logic       write_cfg;
  logic [1:0] sreg_out;

  modport master (output shift, output sclk, output serial_in, output write_cfg, input sreg_out);
  modport slave  (input shift, input sclk, input serial_in, input write_cfg, output sreg_out);
endinterface

// File: rtl/sreg_target.sv
// IC-side responder for the configuration shift-register protocol.
// Optional write-length check enabled by defining SREG_TGT_LEN_CHECK_EN.
module sreg_target #(
  parameter int unsigned          CHAIN_LEN   = 42,
  parameter int unsigned          SYNC_STAGES = 2,
  parameter logic [CHAIN_LEN-1:0] CFG_RESET   = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  sreg_target_if.slave                      sif,
  output logic [CHAIN_LEN-1:0]              cfg_out,
  output logic                              cfg_upd,
  output logic                              len_err,
  output logic                              busy,
  output logic [$clog2(CHAIN_LEN+1)-1:0]    bit_cnt
);
  localparam int unsigned HALF = CHAIN_LEN / 2;
  localparam int unsigned CW   = $clog2(CHAIN_LEN + 1);
  localparam int unsigned SW   = SYNC_STAGES * 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_SHIFT   = 2'd2;
  localparam logic [1:0] ST_COMMIT  = 2'd3;

  logic [SW-1:0]        sync_q, sync_d;
  logic [3:0]           in_s;
  logic [1:0]           prev_q, prev_d;
  logic                 shift_rise, shift_fall, sclk_rise;
  logic [1:0]           state_q, state_d;
  logic                 wr_mode_q, wr_mode_d;
  logic [CHAIN_LEN-1:0] chain_q, chain_d;
  logic [CHAIN_LEN-1:0] cfg_q, cfg_d;
  logic                 cfg_upd_q, cfg_upd_d;
  logic                 len_err_q, len_err_d;
  logic                 busy_q, busy_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;

  // Synchronizer: 4 lanes per stage {write_cfg, serial_in, sclk, shift}, stage 0 in the low nibble.
  always_comb begin
    sync_d     = SW'({sync_q, sif.write_cfg, sif.serial_in, sif.sclk, sif.shift});
    in_s       = sync_q[SW-1 -: 4];
    prev_d     = in_s[1:0];
    shift_rise = in_s[0] & ~prev_q[0];
    shift_fall = ~in_s[0] & prev_q[0];
    sclk_rise  = in_s[1] & ~prev_q[1];
  end

  // Transaction FSM and datapath next-state.
  always_comb begin
    state_d   = state_q;
    wr_mode_d = wr_mode_q;
    chain_d   = chain_q;
    cfg_d     = cfg_q;
    cfg_upd_d = 1'b0;
    len_err_d = 1'b0;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (shift_rise) begin
          wr_mode_d = in_s[3];
          state_d   = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        chain_d   = cfg_q;
        bit_cnt_d = '0;
        state_d   = shift_fall ? ST_IDLE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (sclk_rise) begin
          chain_d = {chain_q[CHAIN_LEN-2:0], in_s[2]};
          if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + CW'(1);
        end
        if (shift_fall) state_d = wr_mode_q ? ST_COMMIT : ST_IDLE;
      end
      ST_COMMIT: begin
`ifdef SREG_TGT_LEN_CHECK_EN
        if (bit_cnt_q == CW'(CHAIN_LEN)) begin
          cfg_d     = chain_q;
          cfg_upd_d = 1'b1;
        end else begin
          len_err_d = 1'b1;
        end
`else
        cfg_d     = chain_q;
        cfg_upd_d = 1'b1;
`endif
        if (shift_rise) begin
          wr_mode_d = in_s[3];
          state_d   = ST_CAPTURE;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      prev_q    <= '0;
      state_q   <= ST_IDLE;
      wr_mode_q <= 1'b0;
      chain_q   <= '0;
      cfg_q     <= CFG_RESET;
      cfg_upd_q <= 1'b0;
      len_err_q <= 1'b0;
      busy_q    <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      state_q   <= state_d;
      wr_mode_q <= wr_mode_d;
      chain_q   <= chain_d;
      cfg_q     <= cfg_d;
      cfg_upd_q <= cfg_upd_d;
      len_err_q <= len_err_d;
      busy_q    <= busy_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign sif.sreg_out = {chain_q[HALF-1], chain_q[CHAIN_LEN-1]};
  assign cfg_out      = cfg_q;
  assign cfg_upd      = cfg_upd_q;
  assign len_err      = len_err_q;
  assign busy         = busy_q;
  assign bit_cnt      = bit_cnt_q;
endmodule

// File: tb/tb_sreg_target.sv
// Directed self-checking bench for sreg_target (42-bit chain, 2-stage sync).
module tb_sreg_target;
  localparam int unsigned N    = 42;
  localparam int unsigned SYNC = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] cfg_out;
  logic         cfg_upd, len_err, busy;
  logic [5:0]   bit_cnt;

  always #5 clk = ~clk;

  sreg_target_if sif();

  sreg_target #(.CHAIN_LEN(N), .SYNC_STAGES(SYNC), .CFG_RESET('0)) dut (
    .clk(clk), .rst(rst), .sif(sif),
    .cfg_out(cfg_out), .cfg_upd(cfg_upd), .len_err(len_err),
    .busy(busy), .bit_cnt(bit_cnt)
  );

  int tests = 0;
  int fails = 0;

  logic [N-1:0] val_a = 42'h3FF_0000_FFFF;
  logic [N-1:0] val_b = 42'h0AB_CDEF_0123;
  logic [N-1:0] val_c = 42'h012_3456_789A;
  logic [N-1:0] val_d = 42'h2AA_5555_AAAA;
  logic [N-1:0] exp_cfg;
  logic [20:0]  rb0, rb1;
  int           upd_cnt, upd_at, err_cnt, busy_lo, busy_hi;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sclk_pulse(input logic d);
    sif.serial_in = d;
    sif.sclk = 1'b1; cyc(2);
    sif.sclk = 1'b0; cyc(2);
  endtask

  // Full transaction: frame, n bits MSB first, drop frame, watch 10 cycles for pulses.
  task automatic xact(input logic wr, input logic [N-1:0] val, input int n,
                      output logic [20:0] o_rb0, output logic [20:0] o_rb1,
                      output int o_upd_cnt, output int o_upd_at,
                      output int o_err_cnt, output int o_busy_lo);
    o_rb0 = '0; o_rb1 = '0; o_upd_cnt = 0; o_upd_at = 0; o_err_cnt = 0; o_busy_lo = 0;
    sif.write_cfg = wr;
    sif.shift = 1'b1;
    cyc(4);
    sif.write_cfg = ~wr;
    for (int i = 0; i < n; i++) begin
      if (i < 21) begin
        o_rb0 = {o_rb0[19:0], sif.sreg_out[0]};
        o_rb1 = {o_rb1[19:0], sif.sreg_out[1]};
      end
      if (busy !== 1'b1) o_busy_lo++;
      sclk_pulse(val[n-1-i]);
    end
    sif.shift = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      if (cfg_upd === 1'b1) begin o_upd_cnt++; o_upd_at = k; end
      if (len_err === 1'b1) o_err_cnt++;
    end
    sif.write_cfg = 1'b0;
  endtask

  initial begin
    sif.shift = 1'b0; sif.sclk = 1'b0; sif.serial_in = 1'b0; sif.write_cfg = 1'b0;
    rst = 1'b1;
    cyc(2);
    chk("rst_sreg_out", 64'(sif.sreg_out), 64'd0);
    chk("rst_cfg_out",  64'(cfg_out), 64'd0);
    chk("rst_cfg_upd",  64'(cfg_upd), 64'd0);
    chk("rst_len_err",  64'(len_err), 64'd0);
    chk("rst_busy",     64'(busy), 64'd0);
    chk("rst_bit_cnt",  64'(bit_cnt), 64'd0);
    rst = 1'b0;
    cyc(1);

    // Write A after reset: readback of the all-zero reset value.
    xact(1'b1, val_a, 42, rb0, rb1, upd_cnt, upd_at, err_cnt, busy_lo);
    chk("wa_rb0",      64'(rb0), 64'd0);
    chk("wa_rb1",      64'(rb1), 64'd0);
    chk("wa_busy_lo",  64'(busy_lo), 64'd0);
    chk("wa_upd_cnt",  64'(upd_cnt), 64'd1);
    chk("wa_upd_at",   64'(upd_at), 64'(SYNC + 2));
    chk("wa_err_cnt",  64'(err_cnt), 64'd0);
    chk("wa_cfg_out",  64'(cfg_out), 64'(val_a));
    chk("wa_bit_cnt",  64'(bit_cnt), 64'd42);
    chk("wa_busy_end", 64'(busy), 64'd0);

    // Read-only, 21 edges: both halves of A stream out, no commit.
    xact(1'b0, val_d, 21, rb0, rb1, upd_cnt, upd_at, err_cnt, busy_lo);
    chk("rd_rb0",     64'(rb0), 64'(val_a[41:21]));
    chk("rd_rb1",     64'(rb1), 64'(val_a[20:0]));
    chk("rd_upd_cnt", 64'(upd_cnt), 64'd0);
    chk("rd_cfg_out", 64'(cfg_out), 64'(val_a));
    chk("rd_bit_cnt", 64'(bit_cnt), 64'd21);

    // Write B over A with readback of A.
    xact(1'b1, val_b, 42, rb0, rb1, upd_cnt, upd_at, err_cnt, busy_lo);
    chk("wb_rb0",     64'(rb0), 64'(val_a[41:21]));
    chk("wb_rb1",     64'(rb1), 64'(val_a[20:0]));
    chk("wb_upd_cnt", 64'(upd_cnt), 64'd1);
    chk("wb_cfg_out", 64'(cfg_out), 64'(val_b));

    // Short write, 40 edges: chain holds B[1:0] above the 40 new bits.
    xact(1'b1, val_c, 40, rb0, rb1, upd_cnt, upd_at, err_cnt, busy_lo);
    chk("sw_rb0",     64'(rb0), 64'(val_b[41:21]));
    chk("sw_bit_cnt", 64'(bit_cnt), 64'd40);
`ifdef SREG_TGT_LEN_CHECK_EN
    exp_cfg = val_b;
    chk("sw_upd_cnt", 64'(upd_cnt), 64'd0);
    chk("sw_err_cnt", 64'(err_cnt), 64'd1);
`else
    exp_cfg = {val_b[1:0], val_c[39:0]};
    chk("sw_upd_cnt", 64'(upd_cnt), 64'd1);
    chk("sw_err_cnt", 64'(err_cnt), 64'd0);
`endif
    chk("sw_cfg_out", 64'(cfg_out), 64'(exp_cfg));

    // Reset in the middle of a write after 10 edges.
    sif.write_cfg = 1'b1;
    sif.shift = 1'b1;
    cyc(4);
    for (int i = 0; i < 10; i++) sclk_pulse(val_d[N-1-i]);
    chk("mr_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    sif.shift = 1'b0;
    sif.write_cfg = 1'b0;
    cyc(2);
    rst = 1'b0;
    chk("mr_cfg_out",  64'(cfg_out), 64'd0);
    chk("mr_busy",     64'(busy), 64'd0);
    chk("mr_sreg_out", 64'(sif.sreg_out), 64'd0);
    chk("mr_bit_cnt",  64'(bit_cnt), 64'd0);
    upd_cnt = 0; busy_hi = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      if (cfg_upd === 1'b1) upd_cnt++;
      if (busy === 1'b1) busy_hi++;
    end
    chk("mr_upd_cnt", 64'(upd_cnt), 64'd0);
    chk("mr_busy_hi", 64'(busy_hi), 64'd0);

    // Reload A, then toggle sclk with no frame: nothing may move.
    xact(1'b1, val_a, 42, rb0, rb1, upd_cnt, upd_at, err_cnt, busy_lo);
    chk("wa2_cfg_out", 64'(cfg_out), 64'(val_a));
    upd_cnt = 0; busy_hi = 0;
    for (int i = 0; i < 20; i++) begin
      sclk_pulse(1'b1);
      if (busy === 1'b1) busy_hi++;
      if (cfg_upd === 1'b1) upd_cnt++;
    end
    chk("ns_sreg_out", 64'(sif.sreg_out), 64'({val_a[20], val_a[41]}));
    chk("ns_bit_cnt",  64'(bit_cnt), 64'd42);
    chk("ns_cfg_out",  64'(cfg_out), 64'(val_a));
    chk("ns_busy_hi",  64'(busy_hi), 64'd0);
    chk("ns_upd_cnt",  64'(upd_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
